fifo_guarded: RTL and testbench
===============================

# fifo_guarded

Parametrised synchronous FIFO that succeeds the basic single-clock FIFO: adds guarded pointers, an occupancy count, sticky overflow/underflow error flags, registered threshold flags, and a selectable first-word-fall-through (FWFT) read mode. It sits between producer and consumer blocks in one clock domain. Storage is an inferred dual-port RAM with a one-cycle synchronous read.

## Interface
Parameters:
- WIDTH, 16, data word width in bits (≥1)
- DEPTH, 16, storage words; power of two, ≥4
- A_EMPTY, 2, almost_empty asserts when count ≤ A_EMPTY (0 ≤ A_EMPTY < DEPTH)
- A_FULL, 2, almost_full asserts when count ≥ DEPTH − A_FULL (0 ≤ A_FULL < DEPTH)
- FWFT, 0, 0 = standard read (data one cycle after re); 1 = first-word-fall-through

Ports (aw = $clog2(DEPTH)):
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- we  in  1  write request
- dataIn  in  WIDTH  write data
- re  in  1  read request (FWFT: acknowledge of current head word)
- dataOut  out  WIDTH  read data
- data_valid  out  1  standard: one-cycle pulse, dataOut valid; FWFT: level, dataOut holds head word
- full_flag  out  1  count == DEPTH
- almost_full  out  1  count ≥ DEPTH − A_FULL
- empty_flag  out  1  count == 0
- almost_empty  out  1  count ≤ A_EMPTY
- count  out  aw+1  words written and not yet read/acknowledged
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted with nothing readable
- clr_err  in  1  clears overflow/underflow

## Operation
- Pointers front/back are aw+1 bits; extra MSB distinguishes full from empty; wrap from DEPTH−1 to 0 in the low bits, MSB toggles.
- Write accepted iff we && !full_flag, judged on pre-edge state; simultaneous re never makes room for the same-edge write. Rejected write: no pointer/memory change, overflow ← 1.
- Standard mode: read accepted iff re && !empty_flag (pre-edge). Accepted read: front+1, dataOut ← mem[front] at the next edge, data_valid high for exactly that cycle. Rejected read: underflow ← 1, dataOut holds previous value, data_valid 0.
- FWFT mode: internal prefetch moves head word from RAM into output register whenever register is empty or being acknowledged and RAM holds words. re accepted iff re && data_valid; re while !data_valid sets underflow and is ignored. count includes the word in the output register.
- count: +1 on accepted write only, −1 on accepted read only, unchanged on both or neither. All four flags are registered and reflect the post-edge count (no extra cycle of lag).
- Sticky errors: set on the offending edge; clr_err clears them; if clr_err and a new error coincide, error wins (stays 1).
- Reset: front=back=0, count=0, empty_flag=1, almost_empty=1, full_flag=0, almost_full=0 (unless A_FULL ≥ DEPTH, forbidden), data_valid=0, dataOut=0, overflow=underflow=0. RAM contents not cleared. Reset mid-operation discards all data; rst overrides we/re/clr_err on the same edge.

## Timing
- Write at edge N: count/flags updated after edge N.
- Standard read accepted at edge N: dataOut/data_valid after edge N+1 (latency 1).
- FWFT, write into empty FIFO at edge N: data_valid=1 and dataOut=word after edge N+2. Continuous reads with re held at data_valid sustain one word per cycle, no bubbles.
- Simultaneous accepted read+write at any fill level 1..DEPTH−1: both complete in one cycle, count unchanged.
- Write to address being read same edge cannot occur (guarded pointers); RAM read-during-write behaviour irrelevant.

## Test plan
- Reset, then 16 writes 0x0001..0x0010 (DEPTH=16): full_flag=1 after 16th edge, almost_full=1 from count=14, count=16; 17th write 0xBEEF → overflow=1, count stays 16, later reads return 0x0001..0x0010 with no 0xBEEF.
- Standard mode: read from empty → underflow=1, data_valid=0; clr_err for one cycle → underflow=0.
- Fill to 8, then 40 cycles of simultaneous we/re with incrementing data: count stays 8, outputs in order, pointers wrap twice without error.
- FWFT=1: write 0x00AA into empty at edge N → data_valid=1, dataOut=0x00AA after N+2; re for one cycle → data_valid=0, count=0, empty_flag=1.
- Fill to 5, assert rst with we=re=1 → count=0, empty_flag=1, data_valid=0, errors 0; next write/read returns the new word.
- Empty with we=re=1 same cycle (standard): write accepted, read rejected, underflow=1, count=1.

Source files
------------

// File: rtl/fifo_guarded.sv
// fifo_guarded: single-clock FIFO with guarded pointers, occupancy count,
// sticky overflow/underflow flags, registered threshold flags and an optional
// first-word-fall-through read mode. The RAM is read through a registered read
// port (stage p1). That port feeds the output register (stage p2).
module fifo_guarded #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 16,
  parameter int A_EMPTY = 2,
  parameter int A_FULL  = 2,
  parameter int FWFT    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [WIDTH-1:0]         dataIn,
  input  logic                     re,
  output logic [WIDTH-1:0]         dataOut,
  output logic                     data_valid,
  output logic                     full_flag,
  output logic                     almost_full,
  output logic                     empty_flag,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW:0] AE_TH   = CW'(A_EMPTY);
  localparam logic [AW:0] AF_TH   = CW'(DEPTH - A_FULL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ram_rdata_p1;

  logic [AW:0]      front_q, front_d;
  logic [AW:0]      back_q, back_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             empty_q, empty_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             vld_p1_q, vld_p1_d;
  logic             vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0] dout_p2_q, dout_p2_d;

  logic             wr_acc;
  logic             rd_en;
  logic             rd_err;
  logic             consume;
  logic             move;

  // Acceptance, prefetch control and next-state for pointers, count and flags.
  always_comb begin
    wr_acc  = we && !full_q;
    rd_en   = 1'b0;
    rd_err  = 1'b0;
    consume = 1'b0;
    move    = 1'b0;

    if (FWFT != 0) begin
      // Head word is acknowledged out of the output register; the RAM read
      // port prefetches whenever its slot is free or draining this edge.
      consume = re && vld_p2_q;
      rd_err  = re && !vld_p2_q;
      move    = vld_p1_q && (!vld_p2_q || consume);
      rd_en   = (front_q != back_q) && (!vld_p1_q || move);
    end else begin
      consume = re && !empty_q;
      rd_err  = re && empty_q;
      move    = vld_p1_q;
      rd_en   = consume;
    end

    front_d = rd_en  ? front_q + CW'(1) : front_q;
    back_d  = wr_acc ? back_q + CW'(1)  : back_q;

    count_d = count_q;
    if (wr_acc && !consume) begin
      count_d = count_q + CW'(1);
    end else if (!wr_acc && consume) begin
      count_d = count_q - CW'(1);
    end

    // Flags are computed from the post-edge count so they never lag it.
    full_d   = (count_d == DEPTH_C);
    afull_d  = (count_d >= AF_TH);
    empty_d  = (count_d == '0);
    aempty_d = (count_d <= AE_TH);

    // A new error on the same edge as clr_err keeps the flag set.
    ovf_d = (ovf_q && !clr_err) || (we && full_q);
    udf_d = (udf_q && !clr_err) || rd_err;

    vld_p1_d = rd_en || (vld_p1_q && !move);

    if (FWFT != 0) begin
      vld_p2_d = move ? 1'b1 : (consume ? 1'b0 : vld_p2_q);
    end else begin
      vld_p2_d = vld_p1_q;
    end
    dout_p2_d = move ? ram_rdata_p1 : dout_p2_q;
  end

  // RAM write port; guarded pointers keep it off the address being read.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[back_q[AW-1:0]] <= dataIn;
    end
  end

  // --- stage p1: registered RAM read port (holds while the p2 slot is busy)
  always_ff @(posedge clk) begin
    if (rd_en) begin
      ram_rdata_p1 <= mem[front_q[AW-1:0]];
    end
  end

  // Control state and output register; reset discards every stored word.
  always_ff @(posedge clk) begin
    if (rst) begin
      front_q   <= '0;
      back_q    <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      empty_q   <= 1'b1;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      dout_p2_q <= '0;
    end else begin
      front_q   <= front_d;
      back_q    <= back_d;
      count_q   <= count_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      empty_q   <= empty_d;
      aempty_q  <= aempty_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      vld_p1_q  <= vld_p1_d;
      // --- stage p2: output register
      vld_p2_q  <= vld_p2_d;
      dout_p2_q <= dout_p2_d;
    end
  end

  assign dataOut      = dout_p2_q;
  assign data_valid   = vld_p2_q;
  assign full_flag    = full_q;
  assign almost_full  = afull_q;
  assign empty_flag   = empty_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_guarded.sv
// tb_fifo_guarded: directed bench for a standard-mode and an FWFT-mode FIFO.
// Expected read words are queued when written; monitors pop and compare them
// whenever a DUT presents a word.
module tb_fifo_guarded;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // standard-mode DUT signals
  logic        s_rst, s_we, s_re, s_clr;
  logic [15:0] s_din, s_dout;
  logic        s_dv, s_full, s_af, s_empty, s_ae, s_ovf, s_udf;
  logic [4:0]  s_cnt;

  // FWFT-mode DUT signals
  logic        f_rst, f_we, f_re, f_clr;
  logic [15:0] f_din, f_dout;
  logic        f_dv, f_full, f_af, f_empty, f_ae, f_ovf, f_udf;
  logic [4:0]  f_cnt;

  logic [15:0] sq [$];
  logic [15:0] fq [$];

  fifo_guarded #(.WIDTH(16), .DEPTH(16), .A_EMPTY(2), .A_FULL(2), .FWFT(0)) u_std (
    .clk(clk), .rst(s_rst), .we(s_we), .dataIn(s_din), .re(s_re),
    .dataOut(s_dout), .data_valid(s_dv), .full_flag(s_full),
    .almost_full(s_af), .empty_flag(s_empty), .almost_empty(s_ae),
    .count(s_cnt), .overflow(s_ovf), .underflow(s_udf), .clr_err(s_clr)
  );

  fifo_guarded #(.WIDTH(16), .DEPTH(16), .A_EMPTY(2), .A_FULL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(f_rst), .we(f_we), .dataIn(f_din), .re(f_re),
    .dataOut(f_dout), .data_valid(f_dv), .full_flag(f_full),
    .almost_full(f_af), .empty_flag(f_empty), .almost_empty(f_ae),
    .count(f_cnt), .overflow(f_ovf), .underflow(f_udf), .clr_err(f_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Standard-mode monitor: every data_valid pulse must carry the next queued word.
  always @(negedge clk) begin
    if (s_dv === 1'b1) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL std_unexpected_valid actual=%0h required=none", s_dout);
      end else begin
        logic [15:0] e;
        e = sq.pop_front();
        if (s_dout !== e) begin
          errors++;
          $display("FAIL std_data actual=%0h required=%0h", s_dout, e);
        end
      end
    end
  end

  // FWFT monitor: compare the head word on each acknowledged cycle.
  always @(negedge clk) begin
    if (f_re === 1'b1 && f_dv === 1'b1) begin
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL fwft_unexpected_word actual=%0h required=none", f_dout);
      end else begin
        logic [15:0] e;
        e = fq.pop_front();
        if (f_dout !== e) begin
          errors++;
          $display("FAIL fwft_data actual=%0h required=%0h", f_dout, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_rst = 1'b1; s_we = 1'b0; s_re = 1'b0; s_clr = 1'b0; s_din = '0;
    f_rst = 1'b1; f_we = 1'b0; f_re = 1'b0; f_clr = 1'b0; f_din = '0;
    tick(); tick();
    s_rst = 1'b0; f_rst = 1'b0;

    // Reset state
    chk("rst_count", s_cnt, 0);
    chk("rst_empty", s_empty, 1);
    chk("rst_aempty", s_ae, 1);
    chk("rst_full", s_full, 0);
    chk("rst_afull", s_af, 0);
    chk("rst_dv", s_dv, 0);
    chk("rst_dout", s_dout, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_udf", s_udf, 0);

    // Fill with 0x0001..0x0010
    s_we = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_din = 16'(i);
      sq.push_back(16'(i));
      tick();
      chk("fill_count", s_cnt, i);
      if (i == 2)  chk("aempty_at_2", s_ae, 1);
      if (i == 3)  chk("aempty_at_3", s_ae, 0);
      if (i == 13) chk("afull_at_13", s_af, 0);
      if (i == 14) chk("afull_at_14", s_af, 1);
      if (i == 15) chk("full_at_15", s_full, 0);
    end
    chk("full_at_16", s_full, 1);

    // Write while full is rejected
    s_din = 16'hBEEF;
    tick();
    s_we = 1'b0;
    chk("ovf_set", s_ovf, 1);
    chk("ovf_count", s_cnt, 16);
    chk("ovf_full", s_full, 1);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    chk("ovf_clr", s_ovf, 0);

    // Drain 16 words; the monitor checks order and absence of 0xBEEF
    s_re = 1'b1;
    repeat (16) tick();
    s_re = 1'b0;
    chk("drain_count", s_cnt, 0);
    chk("drain_empty", s_empty, 1);
    tick(); tick();
    chk("drain_queue", sq.size(), 0);
    chk("drain_udf", s_udf, 0);

    // Read from empty
    s_re = 1'b1;
    tick();
    s_re = 1'b0;
    chk("udf_set", s_udf, 1);
    chk("udf_count", s_cnt, 0);
    tick();
    chk("udf_dv", s_dv, 0);
    chk("udf_dout_hold", s_dout, 16'h0010);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    chk("udf_clr", s_udf, 0);

    // Empty with simultaneous write and read: write wins, read rejected
    s_we = 1'b1; s_re = 1'b1; s_din = 16'h0055;
    sq.push_back(16'h0055);
    tick();
    s_re = 1'b0;
    chk("wr_rd_empty_count", s_cnt, 1);
    chk("wr_rd_empty_udf", s_udf, 1);
    chk("wr_rd_empty_empty", s_empty, 0);

    // Fill to 8, then 40 cycles of simultaneous write/read
    s_clr = 1'b1;
    for (int i = 0; i < 7; i++) begin
      s_din = 16'h0100 + 16'(i);
      sq.push_back(s_din);
      tick();
      s_clr = 1'b0;
    end
    chk("fill8_count", s_cnt, 8);
    chk("fill8_udf", s_udf, 0);
    s_re = 1'b1;
    begin
      int bad_cnt;
      bad_cnt = 0;
      for (int i = 0; i < 40; i++) begin
        s_din = 16'h0200 + 16'(i);
        sq.push_back(s_din);
        tick();
        if (s_cnt !== 5'd8) bad_cnt++;
      end
      chk("stream_count_steady", bad_cnt, 0);
    end
    s_we = 1'b0;
    chk("stream_ovf", s_ovf, 0);
    chk("stream_udf", s_udf, 0);
    repeat (8) tick();
    s_re = 1'b0;
    tick(); tick();
    chk("stream_empty", s_empty, 1);
    chk("stream_queue", sq.size(), 0);

    // Reset mid-operation overrides we/re
    s_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_din = 16'h0300 + 16'(i);
      tick();
    end
    chk("prerst_count", s_cnt, 5);
    s_rst = 1'b1; s_re = 1'b1; s_din = 16'h0399;
    tick();
    s_rst = 1'b0; s_we = 1'b0; s_re = 1'b0;
    chk("midrst_count", s_cnt, 0);
    chk("midrst_empty", s_empty, 1);
    chk("midrst_dv", s_dv, 0);
    chk("midrst_ovf", s_ovf, 0);
    chk("midrst_udf", s_udf, 0);
    s_we = 1'b1; s_din = 16'h0777;
    sq.push_back(16'h0777);
    tick();
    s_we = 1'b0; s_re = 1'b1;
    tick();
    s_re = 1'b0;
    tick(); tick();
    chk("postrst_queue", sq.size(), 0);

    // FWFT: reset state
    chk("f_rst_dv", f_dv, 0);
    chk("f_rst_empty", f_empty, 1);

    // FWFT: write 0x00AA into empty, visible two edges later
    f_we = 1'b1; f_din = 16'h00AA;
    fq.push_back(16'h00AA);
    tick();
    f_we = 1'b0;
    chk("f_n0_dv", f_dv, 0);
    chk("f_n0_count", f_cnt, 1);
    tick();
    chk("f_n1_dv", f_dv, 0);
    tick();
    chk("f_n2_dv", f_dv, 1);
    chk("f_n2_dout", f_dout, 16'h00AA);
    chk("f_n2_count", f_cnt, 1);
    f_re = 1'b1;
    tick();
    f_re = 1'b0;
    chk("f_ack_dv", f_dv, 0);
    chk("f_ack_count", f_cnt, 0);
    chk("f_ack_empty", f_empty, 1);
    chk("f_ack_udf", f_udf, 0);

    // FWFT: acknowledge with nothing presented
    f_re = 1'b1;
    tick();
    f_re = 1'b0;
    chk("f_udf_set", f_udf, 1);
    chk("f_udf_count", f_cnt, 0);
    f_clr = 1'b1;
    tick();
    f_clr = 1'b0;
    chk("f_udf_clr", f_udf, 0);

    // FWFT: six words streamed out with re held, no bubbles
    f_we = 1'b1;
    for (int i = 0; i < 6; i++) begin
      f_din = 16'h00B0 + 16'(i);
      fq.push_back(f_din);
      tick();
    end
    f_we = 1'b0;
    chk("f_burst_count", f_cnt, 6);
    chk("f_burst_dv", f_dv, 1);
    f_re = 1'b1;
    begin
      int gaps;
      gaps = 0;
      for (int i = 0; i < 6; i++) begin
        if (f_dv !== 1'b1) gaps++;
        tick();
      end
      chk("f_no_bubbles", gaps, 0);
    end
    f_re = 1'b0;
    chk("f_burst_end_dv", f_dv, 0);
    chk("f_burst_end_count", f_cnt, 0);
    chk("f_queue", fq.size(), 0);
    chk("f_burst_udf", f_udf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
